cluster_frame_scheduler: RTL and testbench

//  Sequences the 8 per-frame clusters from the 1536-strip first-8 encoder onto one shared

---
 rtl/cluster_pkg.sv | 43 ++++
 rtl/cluster_frame_scheduler_first1of8.sv | 29 ++
 rtl/cluster_frame_scheduler.sv | 163 ++++++++++++++++
 tb/tb_cluster_frame_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_pkg.sv
// ---------------------------------------------------------------------------
// cluster_pkg
// Shared constants and types for the cluster frame scheduler.
//   NSLOTS      : clusters per encoder frame
//   ADR_INVALID : slot address at or above this value marks an empty slot
//   ADR_MARKER  : address carried by the empty-frame marker word
//   cluster_t   : one cluster {adr, cnt}
//   frame_t     : one buffered frame {clusters, pending-slot mask, frame id}
// ---------------------------------------------------------------------------
package cluster_pkg;

    localparam int NSLOTS = 8;
    localparam int ADR_W  = 11;
    localparam int CNT_W  = 3;
    localparam int IDX_W  = 3;
    localparam int FID_W  = 12;
    localparam int OVF_W  = 16;

    localparam logic [ADR_W-1:0] ADR_INVALID = 11'd1536;
    localparam logic [ADR_W-1:0] ADR_MARKER  = 11'h7FF;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [CNT_W-1:0] cnt;
    } cluster_t;

    typedef struct packed {
        cluster_t [NSLOTS-1:0] clu;
        logic     [NSLOTS-1:0] mask;
        logic     [FID_W-1:0]  fid;
    } frame_t;

    // Slots whose address is a real strip address (below ADR_INVALID).
    function automatic logic [NSLOTS-1:0] valid_mask(input logic [NSLOTS*ADR_W-1:0] adr);
        logic [NSLOTS-1:0] m;
        m = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            m[i] = (adr[ADR_W*i +: ADR_W] < ADR_INVALID);
        end
        return m;
    endfunction

endpackage

// File: rtl/cluster_frame_scheduler_first1of8.sv
// ---------------------------------------------------------------------------
// first1of8
// Combinational lowest-set-bit picker for an 8-bit slot mask.
//   mask_i    : pending slots
//   idx_o     : index of the lowest set bit (0 when mask is empty)
//   any_o     : at least one bit set
//   is_last_o : exactly one bit set, i.e. the picked slot is the final one
// ---------------------------------------------------------------------------
module first1of8
    import cluster_pkg::*;
(
    input  logic [NSLOTS-1:0] mask_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o,
    output logic              is_last_o
);

    always_comb begin
        idx_o = '0;
        // Scan from the top so the lowest set bit wins.
        for (int i = NSLOTS-1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = 3'(i);
        end
        any_o     = |mask_i;
        // Clearing the lowest set bit leaves zero only if it was the sole bit.
        is_last_o = any_o && ((mask_i & (mask_i - 8'd1)) == 8'd0);
    end

endmodule

// File: rtl/cluster_frame_scheduler.sv
// ---------------------------------------------------------------------------
// cluster_frame_scheduler
// Serialises the 8 per-frame clusters of the strip encoder onto a single
// valid/ready link, one cluster per clock4x. Holds up to two frames in a
// FIFO, skips empty slots, tags each word with its frame id and counts
// frames dropped because both buffers were busy.
//
// Ports
//   clock4x, global_reset       : clock, async active-high reset
//   frame_valid, adr_in, cnt_in : new-frame strobe and its 8 slots
//   clu_ready                   : downstream accept
//   clu_valid/adr/cnt/last/fid  : output word (registered, held until accepted)
//   busy                        : at least one frame buffer occupied
//   ovf_cnt                     : dropped frames, saturating
//
// Build option
//   CLUSTER_EMPTY_MARKER_EN : when defined, a frame with no valid slot is
//   buffered and emits one marker word (adr=7FF, cnt=0, last=1). When
//   undefined, such a frame only advances the frame id and is discarded.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame buffered, output register only drains
// SEND  | head frame present, one slot moved to the output per free slot
// ---------------------------------------------------------------------------
module cluster_frame_scheduler
    import cluster_pkg::*;
(
    input  logic                      clock4x,
    input  logic                      global_reset,
    input  logic                      frame_valid,
    input  logic [NSLOTS*ADR_W-1:0]   adr_in,
    input  logic [NSLOTS*CNT_W-1:0]   cnt_in,
    input  logic                      clu_ready,
    output logic                      clu_valid,
    output logic [ADR_W-1:0]          clu_adr,
    output logic [CNT_W-1:0]          clu_cnt,
    output logic                      clu_last,
    output logic [FID_W-1:0]          clu_fid,
    output logic                      busy,
    output logic [OVF_W-1:0]          ovf_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    frame_t            fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic [FID_W-1:0]  fid_q;
    logic [OVF_W-1:0]  ovf_q;

    logic              valid_q;
    logic [ADR_W-1:0]  adr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;
    logic [FID_W-1:0]  ofid_q;

    frame_t            head;
    frame_t            new_frame;
    logic [NSLOTS-1:0] new_mask;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any, pick_last;
    logic              load, pop, store_frame, full_eff, push, drop;

    assign head = fifo_q[rd_ptr_q];

    first1of8 u_pick (
        .mask_i    (head.mask),
        .idx_o     (pick_idx),
        .any_o     (pick_any),
        .is_last_o (pick_last)
    );

    always_comb begin
        new_mask = valid_mask(adr_in);
        new_frame.mask = new_mask;
        new_frame.fid  = fid_q;
        for (int i = 0; i < NSLOTS; i++) begin
            new_frame.clu[i].adr = adr_in[ADR_W*i +: ADR_W];
            new_frame.clu[i].cnt = cnt_in[CNT_W*i +: CNT_W];
        end

`ifdef CLUSTER_EMPTY_MARKER_EN
        store_frame = frame_valid;
`else
        store_frame = frame_valid && (new_mask != '0);
`endif

        // Output register is a one-word pipeline stage: refill when empty or draining.
        load = (state_q == S_SEND) && (!valid_q || clu_ready);
        // An empty head mask only exists for a buffered marker frame; it retires in one word.
        pop  = load && (pick_last || !pick_any);

        // A buffer retiring this cycle is free for an arriving frame.
        full_eff = (count_q == 2'd2) && !pop;
        push     = store_frame && !full_eff;
        drop     = store_frame && full_eff;

        count_d = count_q + {1'b0, push} - {1'b0, pop};
        state_d = (count_d != 2'd0) ? S_SEND : S_IDLE;
    end

    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            fid_q    <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
            adr_q    <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            ofid_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;

            if (frame_valid) fid_q <= fid_q + 1'b1;
            if (drop && (ovf_q != '1)) ovf_q <= ovf_q + 1'b1;

            if (load) begin
                valid_q <= 1'b1;
                ofid_q  <= head.fid;
                if (pick_any) begin
                    adr_q  <= head.clu[pick_idx].adr;
                    cnt_q  <= head.clu[pick_idx].cnt;
                    last_q <= pick_last;
                end else begin
                    adr_q  <= ADR_MARKER;
                    cnt_q  <= '0;
                    last_q <= 1'b1;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                else     fifo_q[rd_ptr_q].mask[pick_idx] <= 1'b0;
            end else if (clu_ready) begin
                valid_q <= 1'b0;
            end

            // Placed after the head update: with a full FIFO retiring its head,
            // the write pointer aliases the head entry and the new frame must win.
            if (push) begin
                fifo_q[wr_ptr_q] <= new_frame;
                wr_ptr_q         <= ~wr_ptr_q;
            end
        end
    end

    assign clu_valid = valid_q;
    assign clu_adr   = adr_q;
    assign clu_cnt   = cnt_q;
    assign clu_last  = last_q;
    assign clu_fid   = ofid_q;
    assign busy      = (count_q != 2'd0);
    assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_cluster_frame_scheduler.sv
module tb_cluster_frame_scheduler;

    logic        clock4x = 1'b0;
    logic        global_reset;
    logic        frame_valid;
    logic [87:0] adr_in;
    logic [23:0] cnt_in;
    logic        clu_ready;
    logic        clu_valid;
    logic [10:0] clu_adr;
    logic [2:0]  clu_cnt;
    logic        clu_last;
    logic [11:0] clu_fid;
    logic        busy;
    logic [15:0] ovf_cnt;

`ifdef CLUSTER_EMPTY_MARKER_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    cluster_frame_scheduler dut (
        .clock4x      (clock4x),
        .global_reset (global_reset),
        .frame_valid  (frame_valid),
        .adr_in       (adr_in),
        .cnt_in       (cnt_in),
        .clu_ready    (clu_ready),
        .clu_valid    (clu_valid),
        .clu_adr      (clu_adr),
        .clu_cnt      (clu_cnt),
        .clu_last     (clu_last),
        .clu_fid      (clu_fid),
        .busy         (busy),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 clock4x = ~clock4x;

    int vectors     = 0;
    int miscompares = 0;
    int acc_cnt     = 0;
    int tb_fid      = 0;
    int exp_ovf     = 0;

    // Expected word: {adr[26:16], cnt[15:13], last[12], fid[11:0]}
    logic [26:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares accepted words and checks hold stability.
    logic        prev_hold = 1'b0;
    logic [26:0] prev_word;
    logic [26:0] cur_word;
    logic [26:0] e;
    always @(negedge clock4x) begin
        cur_word = {clu_adr, clu_cnt, clu_last, clu_fid};
        if (global_reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("hold_stable", 32'(cur_word), 32'(prev_word));
            if (clu_valid && clu_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("word_adr",  32'(clu_adr),  32'(e[26:16]));
                    chk("word_cnt",  32'(clu_cnt),  32'(e[15:13]));
                    chk("word_last", 32'(clu_last), 32'(e[12]));
                    chk("word_fid",  32'(clu_fid),  32'(e[11:0]));
                end
                acc_cnt++;
                prev_hold = 1'b0;
            end else begin
                prev_hold = clu_valid;
            end
            prev_word = cur_word;
        end
    end

    function automatic logic [87:0] adr_seq(input int base, input int step, input int nvalid);
        logic [87:0] v;
        for (int i = 0; i < 8; i++) v[11*i +: 11] = (i < nvalid) ? 11'(base + step*i) : 11'd1536;
        return v;
    endfunction

    function automatic logic [23:0] cnt_seq(input int seed);
        logic [23:0] v;
        for (int i = 0; i < 8; i++) v[3*i +: 3] = 3'((seed + i) % 8);
        return v;
    endfunction

    task automatic expect_frame(input logic [87:0] a, input logic [23:0] c, input int fid);
        int last_i;
        last_i = -1;
        for (int i = 0; i < 8; i++) if (a[11*i +: 11] < 11'd1536) last_i = i;
        for (int i = 0; i < 8; i++) begin
            if (a[11*i +: 11] < 11'd1536)
                exp_q.push_back({a[11*i +: 11], c[3*i +: 3], (i == last_i), 12'(fid)});
        end
        if (last_i < 0 && MARK) exp_q.push_back({11'h7FF, 3'd0, 1'b1, 12'(fid)});
    endtask

    // Called at posedge+1; strobe is sampled at the next posedge.
    task automatic send_frame(input logic [87:0] a, input logic [23:0] c, input bit accepted);
        frame_valid = 1'b1;
        adr_in      = a;
        cnt_in      = c;
        if (accepted) expect_frame(a, c, tb_fid);
        else          exp_ovf++;
        tb_fid++;
        @(posedge clock4x);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clock4x);
            #1;
            c++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    logic [87:0] a_v;
    logic [23:0] c_v;
    logic [3:0]  pat;
    int          base;

    initial begin
        global_reset = 1'b1;
        frame_valid  = 1'b0;
        adr_in       = '0;
        cnt_in       = '0;
        clu_ready    = 1'b1;
        repeat (3) @(posedge clock4x);
        #1;
        chk("rst_valid", 32'(clu_valid), 32'd0);
        chk("rst_adr",   32'(clu_adr),   32'd0);
        chk("rst_cnt",   32'(clu_cnt),   32'd0);
        chk("rst_last",  32'(clu_last),  32'd0);
        chk("rst_fid",   32'(clu_fid),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ovf",   32'(ovf_cnt),   32'd0);
        global_reset = 1'b0;
        repeat (2) @(posedge clock4x);
        #1;

        // 1: five valid slots, latency and back-to-back words
        send_frame(adr_seq(10, 10, 5), cnt_seq(1), 1'b1);
        @(negedge clock4x);
        chk("t1_lat0", 32'(clu_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock4x);
            chk("t1_stream", 32'(clu_valid), 32'd1);
        end
        @(negedge clock4x);
        chk("t1_done", 32'(clu_valid), 32'd0);
        chk("t1_sb", 32'(exp_q.size()), 32'd0);
        @(posedge clock4x);
        #1;

        // 1b: interleaved holes, 1535 valid, 1536 and 2047 skipped
        a_v = adr_seq(200, 3, 8);
        a_v[0*11 +: 11] = 11'd1536;
        a_v[2*11 +: 11] = 11'h7FF;
        a_v[3*11 +: 11] = 11'd1535;
        a_v[7*11 +: 11] = 11'd1536;
        send_frame(a_v, cnt_seq(5), 1'b1);
        drain("t1b_drain", 40);

        // 2: full frame under backpressure 1,0,0,1
        pat = 4'b1001;
        send_frame(adr_seq(300, 7, 8), cnt_seq(2), 1'b1);
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            clu_ready = pat[c % 4];
            @(posedge clock4x);
            #1;
        end
        clu_ready = 1'b1;
        chk("t2_drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clock4x);
        #1;

        // 3: overflow with ready held low
        clu_ready = 1'b0;
        send_frame(adr_seq(400, 1, 8), cnt_seq(3), 1'b1);
        repeat (7) @(posedge clock4x);
        #1;
        send_frame(adr_seq(500, 1, 8), cnt_seq(4), 1'b1);
        repeat (7) @(posedge clock4x);
        #1;
        send_frame(adr_seq(600, 1, 8), cnt_seq(6), 1'b0);
        @(negedge clock4x);
        chk("t3_ovf",  32'(ovf_cnt), 32'(exp_ovf));
        chk("t3_busy", 32'(busy), 32'd1);
        @(posedge clock4x);
        #1;
        clu_ready = 1'b1;
        drain("t3_drain", 60);
        send_frame(adr_seq(700, 2, 8), cnt_seq(7), 1'b1);
        drain("t3_next", 40);
        repeat (2) @(posedge clock4x);
        #1;

        // 4: arrival while the head's last word retires with both buffers full
        clu_ready = 1'b0;
        send_frame(adr_seq(100, 1, 2), cnt_seq(0), 1'b1);
        repeat (2) @(posedge clock4x);
        #1;
        send_frame(adr_seq(800, 1, 8), cnt_seq(1), 1'b1);
        repeat (2) @(posedge clock4x);
        #1;
        clu_ready = 1'b1;
        send_frame(adr_seq(900, 1, 8), cnt_seq(2), 1'b1);
        @(negedge clock4x);
        chk("t4_ovf", 32'(ovf_cnt), 32'(exp_ovf));
        drain("t4_drain", 60);
        repeat (2) @(posedge clock4x);
        #1;

        // 5: empty frame, then a normal frame carrying the following fid
        send_frame(adr_seq(0, 0, 0), cnt_seq(0), 1'b1);
        @(negedge clock4x);
        chk("t5_busy", 32'(busy), 32'(MARK));
        @(posedge clock4x);
        #1;
        send_frame(adr_seq(1000, 5, 3), cnt_seq(3), 1'b1);
        drain("t5_drain", 40);
        repeat (2) @(posedge clock4x);
        #1;

        // 6: reset after the third word of a frame is accepted
        base = acc_cnt;
        send_frame(adr_seq(1100, 4, 8), cnt_seq(4), 1'b1);
        for (int c = 0; c < 50 && acc_cnt < base + 3; c++) begin
            @(posedge clock4x);
            #1;
        end
        chk("t6_reach3", 32'(acc_cnt - base), 32'd3);
        #1;
        global_reset = 1'b1;
        #1;
        chk("t6_valid", 32'(clu_valid), 32'd0);
        chk("t6_adr",   32'(clu_adr),   32'd0);
        chk("t6_fid",   32'(clu_fid),   32'd0);
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_ovf",   32'(ovf_cnt),   32'd0);
        exp_q.delete();
        tb_fid  = 0;
        exp_ovf = 0;
        repeat (2) @(posedge clock4x);
        #1;
        global_reset = 1'b0;
        repeat (2) @(posedge clock4x);
        #1;
        send_frame(adr_seq(1200, 9, 6), cnt_seq(5), 1'b1);
        drain("t6_drain", 40);
        repeat (3) @(posedge clock4x);
        #1;
        chk("end_valid", 32'(clu_valid), 32'd0);
        chk("end_busy",  32'(busy),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
